// File: rtl/alu_resp_checker.sv
// ---------------------------------------------------------------------------
// alu_resp_checker
//
// Response checker for the 2-bit-select ALU. It accepts (sel, a, b, res)
// transactions, recomputes the golden result, counts mismatches
// (saturating), captures the first failing transaction and, after
// num_tests_p accepted transactions, declares pass or fail. The verdict is
// sticky until reset.
//
// Handshake: a transaction is accepted on a rising clk edge where
// v_i & ready_o. ready_o is high while checking and low once done. Inputs
// are sampled only on an accept edge; while v_i is low or ready_o is low,
// the inputs are ignored and nothing changes.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   v_i / ready_o         transaction valid / checker can accept
//   sel_i, a_i, b_i       ALU op (00 add, 01 sub, 10 and, 11 or) and operands
//   res_i                 observed ALU result
//   done_o                num_tests_p transactions have been checked
//   pass_o / fail_o       verdict, both low until done_o
//   err_cnt_o             saturating mismatch count
//   err_v_o               first-mismatch capture is valid
//   err_sel_o .. err_exp_o  sel/a/b/observed/expected of the first mismatch
// ---------------------------------------------------------------------------
module alu_resp_checker #(
    parameter int width_p         = 4,
    parameter int num_tests_p     = 4,
    parameter int err_cnt_width_p = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [1:0]                 sel_i,
    input  logic [width_p-1:0]         a_i,
    input  logic [width_p-1:0]         b_i,
    input  logic [width_p-1:0]         res_i,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [err_cnt_width_p-1:0] err_cnt_o,
    output logic                       err_v_o,
    output logic [1:0]                 err_sel_o,
    output logic [width_p-1:0]         err_a_o,
    output logic [width_p-1:0]         err_b_o,
    output logic [width_p-1:0]         err_res_o,
    output logic [width_p-1:0]         err_exp_o
);

    // Transaction counter runs 0..num_tests_p.
    localparam int cnt_w = $clog2(num_tests_p + 1);
    localparam logic [cnt_w-1:0] last_c = cnt_w'(num_tests_p);

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    // state_r is the observable FSM state for assertion binding.
    state_e                     state_r;
    logic [cnt_w-1:0]           cnt_r;
    logic [cnt_w-1:0]           cnt_next;
    logic [width_p-1:0]         exp_w;
    logic                       accept;
    logic                       mism;
    logic [err_cnt_width_p-1:0] err_cnt_next;

    // Golden result; add/sub results are truncated to width_p bits so the
    // carry or borrow is dropped.
    always_comb begin
        exp_w = '0;
        unique case (sel_i)
            2'b00:   exp_w = a_i + b_i;
            2'b01:   exp_w = a_i - b_i;
            2'b10:   exp_w = a_i & b_i;
            default: exp_w = a_i | b_i;
        endcase
    end

    always_comb begin
        accept       = v_i & ready_o;
        mism         = accept & (res_i != exp_w);
        cnt_next     = cnt_r + 1'b1;
        err_cnt_next = err_cnt_o;
        // Saturate at all-ones instead of wrapping back to zero.
        if (mism && (err_cnt_o != '1)) begin
            err_cnt_next = err_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CHECK;
            cnt_r     <= '0;
            ready_o   <= 1'b1;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            err_cnt_o <= '0;
            err_v_o   <= 1'b0;
            err_sel_o <= '0;
            err_a_o   <= '0;
            err_b_o   <= '0;
            err_res_o <= '0;
            err_exp_o <= '0;
        end else begin
            unique case (state_r)
                ST_CHECK: begin
                    if (accept) begin
                        cnt_r     <= cnt_next;
                        err_cnt_o <= err_cnt_next;
                        if (mism && !err_v_o) begin
                            err_v_o   <= 1'b1;
                            err_sel_o <= sel_i;
                            err_a_o   <= a_i;
                            err_b_o   <= b_i;
                            err_res_o <= res_i;
                            err_exp_o <= exp_w;
                        end
                        // The final transaction's check lands on this same
                        // edge, so the verdict uses the updated count.
                        if (cnt_next == last_c) begin
                            state_r <= ST_DONE;
                            ready_o <= 1'b0;
                            done_o  <= 1'b1;
                            pass_o  <= (err_cnt_next == '0);
                            fail_o  <= (err_cnt_next != '0);
                        end
                    end
                end
                default: begin
                    // Verdict is held until reset; v_i is ignored.
                    state_r <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_resp_checker.sv
// ---------------------------------------------------------------------------
// Bench for alu_resp_checker. Two instances: k=0 uses the default
// parameters (4 tests, 8-bit error count), k=1 uses 6 tests with a 2-bit
// error count to exercise saturation. A behavioural model keeps, per
// instance, the number of accepted transactions, the raw mismatch count and
// the first failing transaction; every cycle the DUT outputs are compared
// against what those quantities imply.
// ---------------------------------------------------------------------------
module tb_alu_resp_checker;

  localparam int W = 4;
  localparam int NT0 = 4;
  localparam int NT1 = 6;
  localparam int ECW0 = 8;
  localparam int ECW1 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         v     [2];
  logic [1:0]   sel   [2];
  logic [W-1:0] a     [2];
  logic [W-1:0] b     [2];
  logic [W-1:0] res   [2];
  logic         ready [2];
  logic         done  [2];
  logic         pass  [2];
  logic         fail  [2];
  logic         err_v [2];
  logic [1:0]   err_sel [2];
  logic [W-1:0] err_a [2];
  logic [W-1:0] err_b [2];
  logic [W-1:0] err_res [2];
  logic [W-1:0] err_exp [2];
  logic [ECW0-1:0] ecnt0;
  logic [ECW1-1:0] ecnt1;

  alu_resp_checker #(.width_p(W), .num_tests_p(NT0), .err_cnt_width_p(ECW0)) dut0 (
    .clk(clk), .reset(reset), .v_i(v[0]), .ready_o(ready[0]),
    .sel_i(sel[0]), .a_i(a[0]), .b_i(b[0]), .res_i(res[0]),
    .done_o(done[0]), .pass_o(pass[0]), .fail_o(fail[0]), .err_cnt_o(ecnt0),
    .err_v_o(err_v[0]), .err_sel_o(err_sel[0]), .err_a_o(err_a[0]),
    .err_b_o(err_b[0]), .err_res_o(err_res[0]), .err_exp_o(err_exp[0])
  );

  alu_resp_checker #(.width_p(W), .num_tests_p(NT1), .err_cnt_width_p(ECW1)) dut1 (
    .clk(clk), .reset(reset), .v_i(v[1]), .ready_o(ready[1]),
    .sel_i(sel[1]), .a_i(a[1]), .b_i(b[1]), .res_i(res[1]),
    .done_o(done[1]), .pass_o(pass[1]), .fail_o(fail[1]), .err_cnt_o(ecnt1),
    .err_v_o(err_v[1]), .err_sel_o(err_sel[1]), .err_a_o(err_a[1]),
    .err_b_o(err_b[1]), .err_res_o(err_res[1]), .err_exp_o(err_exp[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] golden(input logic [1:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    case (s)
      2'd0:    r = (int'(x) + int'(y)) % 16;
      2'd1:    r = (int'(x) - int'(y) + 16) % 16;
      2'd2:    r = int'(x & y);
      default: r = int'(x | y);
    endcase
    return r[W-1:0];
  endfunction

  function automatic int num_tests(input int k);
    return (k == 0) ? NT0 : NT1;
  endfunction

  function automatic int err_max(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  int           m_acc [2];
  int           m_err [2];
  logic         m_fv  [2];
  logic [1:0]   m_fsel [2];
  logic [W-1:0] m_fa  [2];
  logic [W-1:0] m_fb  [2];
  logic [W-1:0] m_fres [2];
  logic [W-1:0] m_fexp [2];
  logic         started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_acc[k] = 0; m_err[k] = 0; m_fv[k] = 1'b0;
        m_fsel[k] = '0; m_fa[k] = '0; m_fb[k] = '0; m_fres[k] = '0; m_fexp[k] = '0;
      end else if (v[k] && (m_acc[k] < num_tests(k))) begin
        logic [W-1:0] g;
        g = golden(sel[k], a[k], b[k]);
        m_acc[k]++;
        if (res[k] != g) begin
          m_err[k]++;
          if (!m_fv[k]) begin
            m_fv[k] = 1'b1; m_fsel[k] = sel[k]; m_fa[k] = a[k];
            m_fb[k] = b[k]; m_fres[k] = res[k]; m_fexp[k] = g;
          end
        end
      end
    end
    if (reset) started = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit  e_done;
        int  e_cnt;
        logic [31:0] act_cnt;
        e_done = (m_acc[k] == num_tests(k));
        e_cnt  = (m_err[k] > err_max(k)) ? err_max(k) : m_err[k];
        act_cnt = (k == 0) ? 32'(ecnt0) : 32'(ecnt1);
        check($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(!e_done));
        check($sformatf("done[%0d]", k), 32'(done[k]), 32'(e_done));
        check($sformatf("pass[%0d]", k), 32'(pass[k]), 32'(e_done && m_err[k] == 0));
        check($sformatf("fail[%0d]", k), 32'(fail[k]), 32'(e_done && m_err[k] != 0));
        check($sformatf("err_cnt[%0d]", k), act_cnt, 32'(e_cnt));
        check($sformatf("err_v[%0d]", k), 32'(err_v[k]), 32'(m_fv[k]));
        check($sformatf("err_sel[%0d]", k), 32'(err_sel[k]), 32'(m_fsel[k]));
        check($sformatf("err_a[%0d]", k), 32'(err_a[k]), 32'(m_fa[k]));
        check($sformatf("err_b[%0d]", k), 32'(err_b[k]), 32'(m_fb[k]));
        check($sformatf("err_res[%0d]", k), 32'(err_res[k]), 32'(m_fres[k]));
        check($sformatf("err_exp[%0d]", k), 32'(err_exp[k]), 32'(m_fexp[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge.
  task automatic send(input int k, input logic [1:0] s, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] r);
    v[k] = 1'b1; sel[k] = s; a[k] = x; b[k] = y; res[k] = r;
    @(posedge clk); #1;
    v[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; sel[k] = '0; a[k] = '0; b[k] = '0; res[k] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready[0]), 32'd1);
    check("reset_done", 32'(done[0]), 32'd0);
    reset = 1'b0;

    // All four ops correct: 1+3=4, 1-3=14, 1&3=1, 1|3=3.
    send(0, 2'd0, 4'd1, 4'd3, 4'd4);
    send(0, 2'd1, 4'd1, 4'd3, 4'd14);
    send(0, 2'd2, 4'd1, 4'd3, 4'd1);
    send(0, 2'd3, 4'd1, 4'd3, 4'd3);
    check("t1_done", 32'(done[0]), 32'd1);
    check("t1_pass", 32'(pass[0]), 32'd1);
    check("t1_ready", 32'(ready[0]), 32'd0);
    check("t1_err_cnt", 32'(ecnt0), 32'd0);
    // Extra valid while done is ignored.
    send(0, 2'd0, 4'd1, 4'd3, 4'd9);
    check("t1_sticky_cnt", 32'(ecnt0), 32'd0);

    // Two mismatches with a 3-cycle gap between transactions 2 and 3.
    do_reset();
    send(0, 2'd0, 4'd1, 4'd3, 4'd4);
    send(0, 2'd1, 4'd1, 4'd3, 4'd2);
    idle(3);
    check("t2_gap_done", 32'(done[0]), 32'd0);
    check("t2_gap_cnt", 32'(ecnt0), 32'd1);
    send(0, 2'd2, 4'd1, 4'd3, 4'd1);
    check("t2_3rd_done", 32'(done[0]), 32'd0);
    send(0, 2'd3, 4'd1, 4'd3, 4'd0);
    check("t2_done", 32'(done[0]), 32'd1);
    check("t2_fail", 32'(fail[0]), 32'd1);
    check("t2_pass", 32'(pass[0]), 32'd0);
    check("t2_err_cnt", 32'(ecnt0), 32'd2);
    check("t2_err_sel", 32'(err_sel[0]), 32'd1);
    check("t2_err_a", 32'(err_a[0]), 32'd1);
    check("t2_err_b", 32'(err_b[0]), 32'd3);
    check("t2_err_res", 32'(err_res[0]), 32'd2);
    check("t2_err_exp", 32'(err_exp[0]), 32'd14);

    // Modular wraparound is not a mismatch.
    do_reset();
    send(0, 2'd0, 4'd15, 4'd1, 4'd0);
    send(0, 2'd1, 4'd0, 4'd1, 4'd15);
    send(0, 2'd0, 4'd8, 4'd8, 4'd0);
    send(0, 2'd1, 4'd3, 4'd9, 4'd10);
    check("t3_err_cnt", 32'(ecnt0), 32'd0);
    check("t3_pass", 32'(pass[0]), 32'd1);

    // Saturating error counter on the 2-bit instance.
    for (int i = 0; i < NT1; i++) begin
      send(1, 2'd0, 4'd2, 4'd2, 4'd5);
    end
    check("t4_sat_cnt", 32'(ecnt1), 32'd3);
    check("t4_sat_fail", 32'(fail[1]), 32'd1);
    check("t4_sat_first_res", 32'(err_res[1]), 32'd5);

    // Reset mid-run discards the captured mismatch.
    do_reset();
    send(0, 2'd0, 4'd1, 4'd3, 4'd4);
    send(0, 2'd1, 4'd1, 4'd3, 4'd2);
    check("t5_pre_err_v", 32'(err_v[0]), 32'd1);
    do_reset();
    check("t5_post_err_v", 32'(err_v[0]), 32'd0);
    check("t5_post_cnt", 32'(ecnt0), 32'd0);
    send(0, 2'd2, 4'd12, 4'd10, 4'd8);
    send(0, 2'd3, 4'd12, 4'd10, 4'd14);
    send(0, 2'd0, 4'd7, 4'd7, 4'd14);
    check("t5_3rd_done", 32'(done[0]), 32'd0);
    send(0, 2'd1, 4'd7, 4'd9, 4'd14);
    check("t5_pass", 32'(pass[0]), 32'd1);

    // Randomized rounds on both instances.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 20; c++) begin
        for (int k = 0; k < 2; k++) begin
          v[k]   = ($urandom_range(0, 3) != 0);
          sel[k] = 2'($urandom_range(0, 3));
          a[k]   = W'($urandom_range(0, 15));
          b[k]   = W'($urandom_range(0, 15));
          res[k] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15))
                                               : golden(sel[k], a[k], b[k]);
        end
        @(posedge clk); #1;
      end
      v[0] = 1'b0; v[1] = 1'b0;
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
